fetch_pc_sequencer: RTL and testbench
=====================================

FETCH_PC_SEQUENCER -- requirements
Module: fetch_pc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the single clock, and rst is the reset, sampled on the clk rising edge.
REQ-002 The ports SHALL be, in order:
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  f_icode  in  4  icode of the instruction decoded at the current pc
  f_valC  in  64  constant/target field of that instruction
  f_valP  in  64  fall-through address of that instruction
  f_stall  in  1  hazard stall from pipeline control; hold pc
  m_mispredict  in  1  memory-stage jXX was not taken
  m_valA  in  64  correct fall-through address for a mispredict
  w_ret  in  1  ret instruction completing writeback
  w_valM  in  64  return address popped by that ret
  pc  out  64  current fetch address (registered)
  pred_pc  out  64  predicted next pc (combinational)
  fetch_valid  out  1  instruction at pc issues this cycle; 0 means bubble
  halted  out  1  halt fetched; sequencer frozen
  err  out  1  invalid icode fetched
  ret_bubbles  out  8  cycles spent in the most recent ret wait, saturating

Function
REQ-003 The block SHALL keep the state register st in {RUN, RET_WAIT, HALTED, ERROR}.
REQ-004 pred_pc SHALL equal f_valC when f_icode is 4'h7 (jXX) or 4'h8 (call); otherwise it SHALL equal f_valP.
REQ-005 fetch_valid SHALL be computed as (st==RUN) & ~f_stall & ~m_mispredict.
REQ-006 Update priority on each clk edge SHALL be: rst > m_mispredict > w_ret > f_stall > normal fetch.
REQ-007 On m_mispredict, in any state: pc <= m_valA, st <= RUN, and halted and err are cleared, because the halt, ret or invalid instruction was on the wrong path.
REQ-008 On w_ret with st==RET_WAIT: pc <= w_valM and st <= RUN.
REQ-009 On w_ret in any other state: ignore w_ret, with no change to any state.
REQ-010 On f_stall with st==RUN: pc and st SHALL hold.
REQ-011 Normal fetch with st==RUN and f_icode in {1,2,3,4,5,6,7,8,A,B}: pc <= pred_pc.
REQ-012 Normal fetch with st==RUN and f_icode==9 (ret): pc holds, st <= RET_WAIT, and ret_bubbles <= 0.
REQ-013 Normal fetch with st==RUN and f_icode==0 (halt): pc holds, st <= HALTED, and halted <= 1.
REQ-014 Normal fetch with st==RUN and f_icode in {C,D,E,F}: pc holds, st <= ERROR, and err <= 1.
REQ-015 In RET_WAIT, ret_bubbles SHALL increment by 1 on every edge, saturating at 8'hFF, including the exit edge (w_ret or m_mispredict).
REQ-016 Outside RET_WAIT, ret_bubbles SHALL hold its value, except as cleared by REQ-012.
REQ-017 In HALTED and ERROR, pc SHALL hold; only m_mispredict or rst leaves these states.
REQ-018 In RET_WAIT, f_stall SHALL have no effect.
REQ-019 pc arithmetic SHALL be a full 64-bit load only, with no increment inside the block and no wrap checking.
REQ-020 Single-cycle latency: a new pc SHALL be visible the cycle after the qualifying edge.

Reset
REQ-021 On rst=1 at a clk edge: pc <= 64'h0, st <= RUN, halted <= 0, err <= 0, ret_bubbles <= 8'h00.
REQ-022 rst SHALL override m_mispredict, w_ret and f_stall asserted in the same cycle.
REQ-023 rst mid-RET_WAIT SHALL abandon the wait; a later w_ret SHALL be ignored until a new ret is fetched.
REQ-024 While rst=1, fetch_valid SHALL still follow REQ-005 combinationally; the consumer ignores it while reset is asserted.

Verification
REQ-025 After reset, f_icode=3 and f_valP=0x0A -> next cycle pc=0x0A, with fetch_valid=1 in the issuing cycle.
REQ-026 Branch predict and recover: f_icode=7, f_valC=0x40, f_valP=0x13 -> pc=0x40; then m_mispredict=1 with m_valA=0x13 -> pc=0x13, st=RUN.
REQ-027 Ret wait: at pc=0x20, f_icode=9 -> pc holds at 0x20 and fetch_valid=0 for 3 cycles; w_ret=1 with w_valM=0x55 in the 3rd cycle -> pc=0x55 and ret_bubbles=3.
REQ-028 Halt: f_icode=0 -> halted=1 and pc frozen; w_ret and f_stall toggles have no effect; rst -> pc=0, halted=0.
REQ-029 Error: f_icode=0xC -> err=1 and fetch_valid=0; m_mispredict with m_valA=0x30 -> err=0, pc=0x30, RUN.
REQ-030 Priority: f_stall=1 and m_mispredict=1 with m_valA=0x70 in the same cycle -> pc=0x70, and fetch_valid=0 in that cycle.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: holds the fetch address and steers it through
// prediction, mispredict recovery, ret stalls, halt and invalid-icode states.
module fetch_pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        f_stall,
  input  logic        m_mispredict,
  input  logic [63:0] m_valA,
  input  logic        w_ret,
  input  logic [63:0] w_valM,
  output logic [63:0] pc,
  output logic [63:0] pred_pc,
  output logic        fetch_valid,
  output logic        halted,
  output logic        err,
  output logic [7:0]  ret_bubbles
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_RET_WAIT,
    ST_HALTED,
    ST_ERROR
  } state_e;

  state_e      st_q, st_d;
  logic [63:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic [7:0]  rb_q, rb_d;

  assign pred_pc = (f_icode == 4'h7 || f_icode == 4'h8) ? f_valC : f_valP;
  assign fetch_valid = (st_q == ST_RUN) & ~f_stall & ~m_mispredict;

  assign pc          = pc_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign ret_bubbles = rb_q;

  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    err_d    = err_q;
    rb_d     = rb_q;

    // Every edge spent waiting counts, including the one that leaves.
    if (st_q == ST_RET_WAIT && rb_q != 8'hFF)
      rb_d = rb_q + 8'd1;

    if (m_mispredict) begin
      pc_d     = m_valA;
      st_d     = ST_RUN;
      halted_d = 1'b0;
      err_d    = 1'b0;
    end else if (w_ret && st_q == ST_RET_WAIT) begin
      pc_d = w_valM;
      st_d = ST_RUN;
    end else if (st_q == ST_RUN && !f_stall) begin
      case (f_icode)
        4'h0: begin
          st_d     = ST_HALTED;
          halted_d = 1'b1;
        end
        4'h9: begin
          st_d = ST_RET_WAIT;
          rb_d = 8'h00;
        end
        4'hC, 4'hD, 4'hE, 4'hF: begin
          st_d  = ST_ERROR;
          err_d = 1'b1;
        end
        default: pc_d = pred_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_RUN;
      pc_q     <= 64'h0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      rb_q     <= 8'h00;
    end else begin
      st_q     <= st_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      rb_q     <= rb_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed scenarios plus random traffic
// compared against a rule-level model of the fetch sequencer.
module tb_fetch_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  f_icode;
  logic [63:0] f_valC, f_valP;
  logic        f_stall, m_mispredict, w_ret;
  logic [63:0] m_valA, w_valM;
  logic [63:0] pc, pred_pc;
  logic        fetch_valid, halted, err;
  logic [7:0]  ret_bubbles;

  int n_checks = 0;
  int n_errors = 0;

  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2, M_ERR = 3;
  int          m_st;
  logic [63:0] m_pc;
  logic        m_h, m_e;
  int          m_rb;

  always #5 clk = ~clk;

  fetch_pc_sequencer dut (
    .clk(clk), .rst(rst),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .f_stall(f_stall), .m_mispredict(m_mispredict), .m_valA(m_valA),
    .w_ret(w_ret), .w_valM(w_valM),
    .pc(pc), .pred_pc(pred_pc), .fetch_valid(fetch_valid),
    .halted(halted), .err(err), .ret_bubbles(ret_bubbles)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] ic,
                     input logic [63:0] vc, input logic [63:0] vp,
                     input logic stl, input logic mp, input logic [63:0] ma,
                     input logic wr, input logic [63:0] wm);
    logic [63:0] exp_pred;
    logic        exp_fv;
    bit          was_wait;
    @(negedge clk);
    rst = r; f_icode = ic; f_valC = vc; f_valP = vp;
    f_stall = stl; m_mispredict = mp; m_valA = ma;
    w_ret = wr; w_valM = wm;
    #1;
    exp_pred = (ic == 4'h7 || ic == 4'h8) ? vc : vp;
    exp_fv   = (m_st == M_RUN) && !stl && !mp;
    check("pc", pc, m_pc);
    check("pred_pc", pred_pc, exp_pred);
    check("fetch_valid", {63'b0, fetch_valid}, {63'b0, exp_fv});
    check("halted", {63'b0, halted}, {63'b0, m_h});
    check("err", {63'b0, err}, {63'b0, m_e});
    check("ret_bubbles", {56'b0, ret_bubbles}, 64'(m_rb));
    if (r) begin
      m_st = M_RUN; m_pc = 0; m_h = 0; m_e = 0; m_rb = 0;
    end else begin
      was_wait = (m_st == M_WAIT);
      if (was_wait && m_rb < 255) m_rb++;
      if (mp) begin
        m_pc = ma; m_st = M_RUN; m_h = 0; m_e = 0;
      end else if (wr && was_wait) begin
        m_pc = wm; m_st = M_RUN;
      end else if (m_st == M_RUN && !stl) begin
        if (ic == 4'h0) begin
          m_st = M_HALT; m_h = 1;
        end else if (ic == 4'h9) begin
          m_st = M_WAIT; m_rb = 0;
        end else if (ic >= 4'hC) begin
          m_st = M_ERR; m_e = 1;
        end else begin
          m_pc = exp_pred;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [63:0] vc,
                       input logic [63:0] vp);
    cyc(0, ic, vc, vp, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_st = M_RUN; m_pc = 0; m_h = 0; m_e = 0; m_rb = 0;
    rst = 1; f_icode = 1; f_valC = 0; f_valP = 0;
    f_stall = 0; m_mispredict = 0; m_valA = 0; w_ret = 0; w_valM = 0;
    @(posedge clk);
    #1;
    cyc(1, 4'h1, 0, 0, 1, 1, 64'h99, 1, 64'h77);
    check("rst_pc", pc, 64'h0);
    check("rst_halted", {63'b0, halted}, 64'h0);
    check("rst_err", {63'b0, err}, 64'h0);
    check("rst_rb", {56'b0, ret_bubbles}, 64'h0);

    fetch(4'h3, 64'h1234, 64'h0A);
    check("simple_pc", pc, 64'h0A);

    fetch(4'h7, 64'h40, 64'h13);
    check("jxx_pc", pc, 64'h40);
    cyc(0, 4'h1, 0, 64'h44, 0, 1, 64'h13, 0, 0);
    check("recover_pc", pc, 64'h13);

    fetch(4'h1, 0, 64'h20);
    fetch(4'h9, 64'hAA, 64'h21);
    check("ret_hold", pc, 64'h20);
    cyc(0, 4'h1, 0, 64'h99, 0, 0, 0, 0, 0);
    cyc(0, 4'h1, 0, 64'h99, 1, 0, 0, 0, 0);
    check("ret_hold2", pc, 64'h20);
    cyc(0, 4'h1, 0, 64'h99, 0, 0, 0, 1, 64'h55);
    check("ret_pc", pc, 64'h55);
    check("ret_rb", {56'b0, ret_bubbles}, 64'h3);

    fetch(4'h0, 0, 64'h60);
    check("halt_flag", {63'b0, halted}, 64'h1);
    cyc(0, 4'h1, 0, 64'h61, 0, 0, 0, 1, 64'h88);
    cyc(0, 4'h1, 0, 64'h61, 1, 0, 0, 0, 0);
    check("halt_frozen", pc, 64'h55);
    cyc(1, 4'h1, 0, 0, 0, 0, 0, 0, 0);
    check("halt_rst_pc", pc, 64'h0);
    check("halt_rst_flag", {63'b0, halted}, 64'h0);

    fetch(4'hC, 0, 64'h8);
    check("err_flag", {63'b0, err}, 64'h1);
    cyc(0, 4'h1, 0, 64'h8, 0, 1, 64'h30, 0, 0);
    check("err_clear", {63'b0, err}, 64'h0);
    check("err_pc", pc, 64'h30);

    cyc(0, 4'h2, 0, 64'h31, 1, 1, 64'h70, 0, 0);
    check("prio_pc", pc, 64'h70);

    fetch(4'h9, 0, 64'h71);
    cyc(1, 4'h1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 4'h1, 0, 64'h5, 1, 0, 0, 1, 64'hDEAD);
    check("stale_ret", pc, 64'h0);

    fetch(4'h9, 0, 64'h1);
    for (int i = 0; i < 300; i++)
      cyc(0, 4'($urandom), 0, 64'h3, 1'($urandom), 0, 0, 0, 0);
    cyc(0, 4'h1, 0, 0, 0, 0, 0, 1, 64'hBEEF);
    check("rb_sat", {56'b0, ret_bubbles}, 64'hFF);
    check("sat_pc", pc, 64'hBEEF);

    for (int i = 0; i < 3000; i++) begin
      logic r, stl, mp, wr;
      logic [3:0] ic;
      r   = ($urandom_range(99) < 2);
      stl = ($urandom_range(99) < 20);
      mp  = ($urandom_range(99) < 8);
      wr  = ($urandom_range(99) < 20);
      if (m_st == M_RUN && !stl) wr = 0;
      ic  = ($urandom_range(99) < 60) ? 4'($urandom_range(8, 1)) :
            4'($urandom);
      cyc(r, ic, {$urandom, $urandom}, {$urandom, $urandom}, stl, mp,
          {$urandom, $urandom}, wr, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
